// File: rtl/sdp_rdma_arb_pkg.sv
// Shared widths, requester indices and the ordering-FIFO entry layout for
// the SDP read-DMA memory arbiter. The optional per-requester grant counters
// are selected in the top level by the SDP_RDMA_ARB_PERF_EN macro.
package sdp_rdma_arb_pkg;

  localparam int ADDR_W   = 64;
  localparam int SIZE_W   = 15;
  localparam int ID_W     = 2;
  localparam int SIZE_LSB = ADDR_W;

  // Requester indices on the rd_req_* / rd_rsp_* vectors.
  localparam logic [ID_W-1:0] REQ_MAIN = 2'd0;
  localparam logic [ID_W-1:0] REQ_B    = 2'd1;
  localparam logic [ID_W-1:0] REQ_N    = 2'd2;
  localparam logic [ID_W-1:0] REQ_E    = 2'd3;

  // One outstanding request: who asked, and how many beats (minus one) it expects.
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [SIZE_W-1:0] size;
  } arb_entry_t;

  localparam int ENTRY_W = $bits(arb_entry_t);

endpackage

// File: rtl/sdp_rdma_arb_fifo.sv
// Flop-based synchronous ordering FIFO. Holds one entry per outstanding
// memory request; the head entry steers returning response beats.
// Push is ignored when full and pop is ignored when empty.
module sdp_rdma_arb_fifo
  import sdp_rdma_arb_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  output logic [ENTRY_W-1:0] head,
  output logic               full,
  output logic               empty,
  output logic [AW:0]        count
);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               do_push;
  logic               do_pop;

  // Flags come straight from the registered count.
  always_comb begin
    full    = (count == (AW+1)'(DEPTH));
    empty   = (count == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    head    = mem[rd_ptr];
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/sdp_rdma_mem_arb.sv
// Merges the four SDP read-DMA request streams onto one memory read port and
// routes in-order response beats back to their requester, using an ordering
// FIFO of {id, size}. Generates per-requester credit pulses.
// Optional feature: define SDP_RDMA_ARB_PERF_EN for saturating 32-bit
// per-requester accepted-request counters on perf_grant_cnt (else constant 0).
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both 1. The arbiter holds valid and payload stable on the memory request
// port until accepted; ready never depends on the same port's valid.
module sdp_rdma_mem_arb
  import sdp_rdma_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int REQ_PD_W   = 79,
  parameter int RSP_PD_W   = 257,
  parameter int MAX_OUTSTD = 16
) (
  input  logic                      nvdla_core_clk,
  input  logic                      nvdla_core_rstn,
  input  logic [NUM_REQ-1:0]        rd_req_valid,
  output logic [NUM_REQ-1:0]        rd_req_ready,
  input  logic [NUM_REQ*REQ_PD_W-1:0] rd_req_pd,
  output logic [NUM_REQ-1:0]        rd_rsp_valid,
  input  logic [NUM_REQ-1:0]        rd_rsp_ready,
  output logic [RSP_PD_W-1:0]       rd_rsp_pd,
  output logic [NUM_REQ-1:0]        rd_cdt_lat_fifo_pop,
  output logic                      mem_rd_req_valid,
  input  logic                      mem_rd_req_ready,
  output logic [REQ_PD_W-1:0]       mem_rd_req_pd,
  input  logic                      mem_rd_rsp_valid,
  output logic                      mem_rd_rsp_ready,
  input  logic [RSP_PD_W-1:0]       mem_rd_rsp_pd,
  output logic                      arb_err,
  output logic [NUM_REQ*32-1:0]     perf_grant_cnt
);

  localparam int CNT_W = $clog2(MAX_OUTSTD) + 1;

  // Arbitration state: rr_start is where the next search begins (last grant + 1).
  logic [ID_W-1:0]    rr_start;
  logic [ID_W-1:0]    rr_grant;
  logic [ID_W-1:0]    rr_idx;
  logic               rr_found;
  logic [ID_W-1:0]    grant;
  logic               lock_q;
  logic [ID_W-1:0]    lock_id;
  logic               req_accept;

  // Ordering FIFO and response tracking.
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_pop;
  arb_entry_t         push_entry;
  logic [ENTRY_W-1:0] head_raw;
  arb_entry_t         head_e;
  logic [SIZE_W-1:0]  beat_cnt;
  logic               rsp_hs;
  logic [NUM_REQ-1:0] cdt_q;
  logic               err_q;

  // Round-robin search from rr_start; the 2-bit index wraps modulo NUM_REQ.
  always_comb begin
    rr_grant = rr_start;
    rr_found = 1'b0;
    rr_idx   = rr_start;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_idx = rr_start + ID_W'(k);
      if (!rr_found && rd_req_valid[rr_idx]) begin
        rr_grant = rr_idx;
        rr_found = 1'b1;
      end
    end
  end

  // Request path: a stalled grant stays locked so the payload cannot change under backpressure.
  always_comb begin
    grant            = lock_q ? lock_id : rr_grant;
    mem_rd_req_valid = (|rd_req_valid) && !fifo_full;
    mem_rd_req_pd    = rd_req_pd[int'(grant)*REQ_PD_W +: REQ_PD_W];
    req_accept       = mem_rd_req_valid && mem_rd_req_ready;
    rd_req_ready     = '0;
    rd_req_ready[grant] = mem_rd_req_ready && !fifo_full;
    push_entry.id    = grant;
    push_entry.size  = mem_rd_req_pd[SIZE_LSB +: SIZE_W];
  end

  // Round-robin pointer and grant lock.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      rr_start <= REQ_MAIN;
      lock_q   <= 1'b0;
      lock_id  <= REQ_MAIN;
    end else begin
      if (req_accept) rr_start <= grant + 1'b1;
      lock_q  <= mem_rd_req_valid && !mem_rd_req_ready;
      lock_id <= grant;
    end
  end

  sdp_rdma_arb_fifo #(
    .DEPTH (MAX_OUTSTD)
  ) u_fifo (
    .clk       (nvdla_core_clk),
    .rst_n     (nvdla_core_rstn),
    .push      (req_accept),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (head_raw),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Response path: the FIFO head picks the destination; data passes straight through.
  always_comb begin
    head_e           = arb_entry_t'(head_raw);
    rd_rsp_pd        = mem_rd_rsp_pd;
    rd_rsp_valid     = '0;
    mem_rd_rsp_ready = 1'b0;
    if (!fifo_empty) begin
      rd_rsp_valid[head_e.id] = mem_rd_rsp_valid;
      mem_rd_rsp_ready        = rd_rsp_ready[head_e.id];
    end
    rsp_hs   = mem_rd_rsp_valid && mem_rd_rsp_ready;
    fifo_pop = rsp_hs && (beat_cnt == head_e.size);
  end

  // Beat counter, credit pulses and sticky error flag.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      beat_cnt <= '0;
      cdt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (fifo_pop)    beat_cnt <= '0;
      else if (rsp_hs) beat_cnt <= beat_cnt + 1'b1;
      cdt_q <= '0;
      if (rsp_hs) cdt_q[head_e.id] <= 1'b1;
      if (mem_rd_rsp_valid && (fifo_count == '0)) err_q <= 1'b1;
    end
  end

  assign rd_cdt_lat_fifo_pop = cdt_q;
  assign arb_err             = err_q;

`ifdef SDP_RDMA_ARB_PERF_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_perf
    logic [31:0] cnt_q;
    // Saturating count of requests accepted for requester i.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
        cnt_q <= '0;
      end else if (req_accept && (grant == ID_W'(i)) && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
    assign perf_grant_cnt[i*32 +: 32] = cnt_q;
  end
`else
  assign perf_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_sdp_rdma_mem_arb.sv
// Bench for sdp_rdma_mem_arb: directed request patterns with an expected
// queue of response destinations, popped by a negedge monitor.
module tb_sdp_rdma_mem_arb;

  localparam int NUM_REQ    = 4;
  localparam int REQ_PD_W   = 79;
  localparam int RSP_PD_W   = 257;
  localparam int MAX_OUTSTD = 16;

  logic                        clk;
  logic                        rst_n;
  logic [NUM_REQ-1:0]          rd_req_valid;
  logic [NUM_REQ-1:0]          rd_req_ready;
  logic [NUM_REQ*REQ_PD_W-1:0] rd_req_pd;
  logic [NUM_REQ-1:0]          rd_rsp_valid;
  logic [NUM_REQ-1:0]          rd_rsp_ready;
  logic [RSP_PD_W-1:0]         rd_rsp_pd;
  logic [NUM_REQ-1:0]          rd_cdt_lat_fifo_pop;
  logic                        mem_rd_req_valid;
  logic                        mem_rd_req_ready;
  logic [REQ_PD_W-1:0]         mem_rd_req_pd;
  logic                        mem_rd_rsp_valid;
  logic                        mem_rd_rsp_ready;
  logic [RSP_PD_W-1:0]         mem_rd_rsp_pd;
  logic                        arb_err;
  logic [NUM_REQ*32-1:0]       perf_grant_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0]  exp_q[$];
  logic [3:0]  exp_pulse = '0;
  int          exp_grants[NUM_REQ] = '{0, 0, 0, 0};

  sdp_rdma_mem_arb #(
    .NUM_REQ    (NUM_REQ),
    .REQ_PD_W   (REQ_PD_W),
    .RSP_PD_W   (RSP_PD_W),
    .MAX_OUTSTD (MAX_OUTSTD)
  ) dut (
    .nvdla_core_clk      (clk),
    .nvdla_core_rstn     (rst_n),
    .rd_req_valid        (rd_req_valid),
    .rd_req_ready        (rd_req_ready),
    .rd_req_pd           (rd_req_pd),
    .rd_rsp_valid        (rd_rsp_valid),
    .rd_rsp_ready        (rd_rsp_ready),
    .rd_rsp_pd           (rd_rsp_pd),
    .rd_cdt_lat_fifo_pop (rd_cdt_lat_fifo_pop),
    .mem_rd_req_valid    (mem_rd_req_valid),
    .mem_rd_req_ready    (mem_rd_req_ready),
    .mem_rd_req_pd       (mem_rd_req_pd),
    .mem_rd_rsp_valid    (mem_rd_rsp_valid),
    .mem_rd_rsp_ready    (mem_rd_rsp_ready),
    .mem_rd_rsp_pd       (mem_rd_rsp_pd),
    .arb_err             (arb_err),
    .perf_grant_cnt      (perf_grant_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [RSP_PD_W-1:0] got,
                       input logic [RSP_PD_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] addr_of(input int id);
    return 64'hA5A5_0000_0000_0000 | 64'(id);
  endfunction

  function automatic logic [REQ_PD_W-1:0] make_pd(input int id, input logic [14:0] size);
    return {size, addr_of(id)};
  endfunction

  // ---------------- driver tasks ----------------
  // Every task starts and ends 1 time unit after a rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rd_req_valid     = '0;
    mem_rd_rsp_valid = 1'b0;
    repeat (n) cyc();
  endtask

  // Single requester alone on the bus, memory ready: accepted this cycle.
  task automatic issue(input int id, input logic [14:0] size);
    rd_req_valid              = '0;
    rd_req_valid[id]          = 1'b1;
    rd_req_pd[id*REQ_PD_W +: REQ_PD_W] = make_pd(id, size);
    mem_rd_req_ready          = 1'b1;
    for (int b = 0; b <= int'(size); b++) exp_q.push_back(2'(id));
    exp_grants[id]++;
    @(negedge clk);
    check("issue_valid", mem_rd_req_valid, 1'b1);
    check("issue_pd", mem_rd_req_pd, make_pd(id, size));
    check("issue_ready", rd_req_ready, 4'b0001 << id);
    cyc();
    rd_req_valid = '0;
  endtask

  // Response beats with random data; the monitor checks routing and pulses.
  task automatic beats(input int n, input logic [3:0] rdy);
    for (int b = 0; b < n; b++) begin
      mem_rd_rsp_valid = 1'b1;
      rd_rsp_ready     = rdy;
      for (int w = 0; w < 8; w++) mem_rd_rsp_pd[w*32 +: 32] = $urandom();
      mem_rd_rsp_pd[256] = 1'($urandom_range(0, 1));
      cyc();
    end
    mem_rd_rsp_valid = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [1:0] id;
    if (!rst_n) begin
      exp_pulse = '0;
    end else begin
      check("cdt_pulse", rd_cdt_lat_fifo_pop, exp_pulse);
      exp_pulse = '0;
      if (mem_rd_rsp_valid && mem_rd_rsp_ready) begin
        check("rsp_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          id = exp_q.pop_front();
          check("rsp_route", rd_rsp_valid, 4'b0001 << id);
          check("rsp_pd", rd_rsp_pd, mem_rd_rsp_pd);
          exp_pulse = 4'b0001 << id;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n            = 1'b0;
    rd_req_valid     = '0;
    rd_req_pd        = '0;
    rd_rsp_ready     = '0;
    mem_rd_req_ready = 1'b0;
    mem_rd_rsp_valid = 1'b0;
    mem_rd_rsp_pd    = '0;
    repeat (3) cyc();

    // Reset values
    check("rst_arb_err", arb_err, 1'b0);
    check("rst_cdt", rd_cdt_lat_fifo_pop, 4'b0);
    check("rst_perf", perf_grant_cnt, '0);
    check("rst_rsp_ready", mem_rd_rsp_ready, 1'b0);
    check("rst_rsp_valid", rd_rsp_valid, 4'b0);
    check("rst_req_valid", mem_rd_req_valid, 1'b0);
    rst_n = 1'b1;
    cyc();

    // Fair rotation: all four valid, memory always ready
    for (int i = 0; i < NUM_REQ; i++) rd_req_pd[i*REQ_PD_W +: REQ_PD_W] = make_pd(i, 15'd0);
    rd_req_valid     = 4'b1111;
    mem_rd_req_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(2'(k % 4));
      exp_grants[k % 4]++;
      @(negedge clk);
      check("rot_pd", mem_rd_req_pd, make_pd(k % 4, 15'd0));
      check("rot_ready", rd_req_ready, 4'b0001 << (k % 4));
      cyc();
    end
    rd_req_valid = '0;
    beats(8, 4'hF);
    idle(2);

    // Grant lock: req1 stalls, req0 arrives, grant must not move
    mem_rd_req_ready = 1'b0;
    rd_req_valid     = 4'b0010;
    @(negedge clk);
    check("lock_pd0", mem_rd_req_pd, make_pd(1, 15'd0));
    check("lock_valid", mem_rd_req_valid, 1'b1);
    cyc();
    rd_req_valid = 4'b0011;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("lock_pd", mem_rd_req_pd, make_pd(1, 15'd0));
      check("lock_ready0", rd_req_ready, 4'b0000);
      cyc();
    end
    mem_rd_req_ready = 1'b1;
    exp_q.push_back(2'd1);
    exp_grants[1]++;
    @(negedge clk);
    check("lock_acc1", rd_req_ready, 4'b0010);
    cyc();
    exp_q.push_back(2'd0);
    exp_grants[0]++;
    @(negedge clk);
    check("lock_next_pd", mem_rd_req_pd, make_pd(0, 15'd0));
    check("lock_acc0", rd_req_ready, 4'b0001);
    cyc();
    rd_req_valid = '0;
    beats(2, 4'hF);
    idle(2);

    // Outstanding limit: 16 accepted, then blocked until a slot frees
    rd_req_valid = 4'b1000;
    for (int k = 0; k < MAX_OUTSTD; k++) begin
      exp_q.push_back(2'd3);
      exp_grants[3]++;
      @(negedge clk);
      check("fill_ready", rd_req_ready, 4'b1000);
      cyc();
    end
    @(negedge clk);
    check("full_valid", mem_rd_req_valid, 1'b0);
    check("full_ready", rd_req_ready, 4'b0000);
    cyc();
    mem_rd_rsp_valid = 1'b1;
    rd_rsp_ready     = 4'hF;
    @(negedge clk);
    check("full_pop_cycle", mem_rd_req_valid, 1'b0);
    cyc();
    mem_rd_rsp_valid = 1'b0;
    exp_q.push_back(2'd3);
    exp_grants[3]++;
    @(negedge clk);
    check("freed_valid", mem_rd_req_valid, 1'b1);
    check("freed_ready", rd_req_ready, 4'b1000);
    cyc();
    rd_req_valid = '0;
    beats(MAX_OUTSTD, 4'hF);
    idle(2);

    // Routing: req2 size 1 then req0 size 0
    issue(2, 15'd1);
    issue(0, 15'd0);
    beats(3, 4'hF);
    idle(2);

    // Response backpressure mid-request
    issue(2, 15'd1);
    issue(0, 15'd0);
    beats(1, 4'hF);
    mem_rd_rsp_valid = 1'b1;
    rd_rsp_ready     = 4'b1011;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("bp_ready", mem_rd_rsp_ready, 1'b0);
      check("bp_valid", rd_rsp_valid, 4'b0100);
      cyc();
    end
    beats(2, 4'hF);
    idle(2);

    // Response with nothing outstanding
    mem_rd_rsp_valid = 1'b1;
    rd_rsp_ready     = 4'hF;
    @(negedge clk);
    check("err_rsp_ready", mem_rd_rsp_ready, 1'b0);
    check("err_rsp_valid", rd_rsp_valid, 4'b0000);
    cyc();
    mem_rd_rsp_valid = 1'b0;
    @(negedge clk);
    check("err_set", arb_err, 1'b1);
    idle(3);
    @(negedge clk);
    check("err_sticky", arb_err, 1'b1);

    // Largest size: 32768 beats for one request, then a follow-up
    cyc();
    issue(0, 15'h7FFF);
    beats(32768, 4'hF);
    issue(1, 15'd0);
    beats(1, 4'hF);
    idle(2);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    for (int i = 0; i < NUM_REQ; i++) begin
`ifdef SDP_RDMA_ARB_PERF_EN
      check("perf_cnt", perf_grant_cnt[i*32 +: 32], 32'(exp_grants[i]));
`else
      check("perf_off", perf_grant_cnt[i*32 +: 32], 32'd0);
`endif
    end

    // Reset mid-burst: pointer, FIFO, counter, pulses and error clear
    issue(1, 15'd3);
    beats(2, 4'hF);
    mem_rd_rsp_valid = 1'b1;
    rst_n            = 1'b0;
    #1;
    check("mrst_cdt", rd_cdt_lat_fifo_pop, 4'b0000);
    check("mrst_err", arb_err, 1'b0);
    check("mrst_rsp_ready", mem_rd_rsp_ready, 1'b0);
    check("mrst_rsp_valid", rd_rsp_valid, 4'b0000);
    check("mrst_perf", perf_grant_cnt, '0);
    exp_q.delete();
    mem_rd_rsp_valid = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    for (int i = 0; i < NUM_REQ; i++) rd_req_pd[i*REQ_PD_W +: REQ_PD_W] = make_pd(i, 15'd0);
    rd_req_valid     = 4'b1111;
    mem_rd_req_ready = 1'b0;
    @(negedge clk);
    check("mrst_ptr", mem_rd_req_pd, make_pd(0, 15'd0));
    check("mrst_err_after", arb_err, 1'b0);
    cyc();
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdp_rdma_mem_arb.md
# sdp_rdma_mem_arb

Merges the four SDP read-DMA request streams (main, B, N, E) onto one memory-interface read port and routes in-order read-response beats back to the originating requester. It sits between the SDP read engines and the MCIF/CVIF read port, so a single memory client port serves all SDP read traffic. Outstanding requests are tracked in an ordering FIFO, and the block generates each requester's `cdt_lat_fifo_pop` credit pulse.

## Interface
Parameters:
- `NUM_REQ`, 4: requester count; index 0=main, 1=B, 2=N, 3=E.
- `REQ_PD_W`, 79: request payload width. Bits [63:0] are the address; bits [78:64] are the size, in 32-byte atoms minus 1.
- `RSP_PD_W`, 257: response payload width (256 data bits + 1 mask bit).
- `MAX_OUTSTD`, 16: maximum number of outstanding requests (ordering FIFO depth, power of two).

Ports:
- `nvdla_core_clk` in 1: the single clock.
- `nvdla_core_rstn` in 1: reset, asynchronous, active-low.
- `rd_req_valid` in NUM_REQ: per-requester request valid.
- `rd_req_ready` out NUM_REQ: per-requester request ready.
- `rd_req_pd` in NUM_REQ*REQ_PD_W: request payloads; requester i occupies slice i.
- `rd_rsp_valid` out NUM_REQ: per-requester response valid.
- `rd_rsp_ready` in NUM_REQ: per-requester response ready.
- `rd_rsp_pd` out RSP_PD_W: response payload, shared by all requesters.
- `rd_cdt_lat_fifo_pop` out NUM_REQ: one-cycle pulse per response beat delivered to that requester.
- `mem_rd_req_valid` / `mem_rd_req_ready` / `mem_rd_req_pd` out / in / out, 1 / 1 / REQ_PD_W: memory request port.
- `mem_rd_rsp_valid` / `mem_rd_rsp_ready` / `mem_rd_rsp_pd` in / out / in, 1 / 1 / RSP_PD_W: memory response port.
- `arb_err` out 1: sticky flag, set when a response arrives with nothing outstanding.
- `perf_grant_cnt` out NUM_REQ*32: per-requester accepted-request counters (see Configuration).

## Operation
**Request arbitration**
- Round-robin: the search starts at (last granted index + 1) mod NUM_REQ; after reset the pointer is 0.
- Grant lock: while `mem_rd_req_valid && !mem_rd_req_ready`, the grant is held, so `mem_rd_req_pd` stays stable and valid stays high.
- Path: `mem_rd_req_valid = |rd_req_valid && !fifo_full`. `mem_rd_req_pd` is the granted slice. Only `rd_req_ready[grant] = mem_rd_req_ready && !fifo_full`; all other readies are 0.
- On accept:
  - push {grant id (2b), size (15b)} into the ordering FIFO;
  - update the round-robin pointer to the grant.

**Response routing**
- Response beats are in-order; the FIFO head selects the destination requester.
- `rd_rsp_valid[head] = mem_rd_rsp_valid && !fifo_empty`.
- `mem_rd_rsp_ready = rd_rsp_ready[head] && !fifo_empty`.
- `rd_rsp_pd = mem_rd_rsp_pd`, passed through unregistered.
- Beat counter (15b):
  - increments on each response handshake;
  - when it equals the head size, the FIFO pops and the counter clears, so each request receives exactly size+1 beats.
- `rd_cdt_lat_fifo_pop[head]` pulses for one cycle, registered, in the cycle after each response handshake.

**Boundaries**
- FIFO full: no requester is granted and `mem_rd_req_valid` is 0. Fullness is computed from the registered count.
- Push and pop in the same cycle: count unchanged. This is legal at any fill level, including full, because push is already blocked when full.
- FIFO empty with `mem_rd_rsp_valid=1`: `mem_rd_rsp_ready=0`, `arb_err` is set; it stays set until reset.
- Size 32767: the counter reaches 32767 and the request completes without overflow.
- Reset mid-operation: pointer, FIFO, counter, pulses and `arb_err` clear immediately; in-flight requests are dropped.

## Timing
- Request path: 0-cycle combinational latency from input to memory port.
- Response path: 0-cycle combinational latency; credit pulse follows 1 cycle later.
- A freed FIFO slot is usable in the cycle after the pop.
- Reset values:
  - `arb_err`, `rd_cdt_lat_fifo_pop` and `perf_grant_cnt` are 0.
  - `mem_rd_rsp_ready` and all `rd_rsp_valid` bits are 0 because the FIFO is empty.
  - `mem_rd_req_valid` and `rd_req_ready` follow their inputs combinationally; they are 0 while reset is asserted only if the inputs are 0.
- Sustained throughput: one request and one response beat per cycle.

## Configuration
- `SDP_RDMA_ARB_PERF_EN` defined: each 32-bit `perf_grant_cnt` slice counts accepted requests for its requester. Counters saturate at 0xFFFFFFFF and are cleared by reset.
- Macro undefined: no counter flops; `perf_grant_cnt` is driven to constant 0.

## Structure
- Package `sdp_rdma_arb_pkg`:
  - width constants (address 64, size 15, id 2);
  - the FIFO entry typedef {id, size};
  - requester index constants.
- Sub-module `sdp_rdma_arb_fifo`: flop-based synchronous FIFO with DEPTH = MAX_OUTSTD, exposing full, empty and count.
- The top level contains the arbiter, beat counter, credit pulses and perf counters.

## Test plan
- **Fair rotation:** all four `rd_req_valid=1`, `mem_rd_req_ready=1` for 8 cycles -> grants 0,1,2,3,0,1,2,3, one per cycle.
- **Grant lock:** req0 and req1 valid, `mem_rd_req_ready=0` for 3 cycles -> grant stays 0 with pd stable; then ready=1 -> req0 accepted, req1 next cycle.
- **Outstanding limit:** 16 requests accepted with no responses -> `mem_rd_req_valid=0` while req valid. Deliver one single-beat response -> a request is accepted in the next cycle.
- **Routing:** req2 issues size=1, then req0 issues size=0; deliver 3 beats -> beats 1-2 reach req2 and beat 3 reaches req0, with `rd_cdt_lat_fifo_pop` pulses 2× on bit 2 and 1× on bit 0.
- **Response backpressure:** `rd_rsp_ready[2]=0` with the head at id 2 -> `mem_rd_rsp_ready=0`, beat counter unchanged and no credit pulse.
- **Error and reset:** FIFO empty, `mem_rd_rsp_valid=1` -> `arb_err=1` and stays set; assert reset mid-burst -> FIFO empty, `arb_err=0` and pointer back to 0.
